// File: rtl/adc366x_pkg.sv
// Shared types and helpers for the ADC366x input-delay calibration sequencer.
package adc366x_pkg;

    localparam int TAP_W = 5;
    localparam int NTAP  = 32;
    localparam int LEN_W = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_SCORE,
        ST_CALC,
        ST_APPLY,
        ST_APPLY_LD,
        ST_DONE,
        ST_LOAD_M
    } cal_st_t;

    // Centre of a run of len taps starting at start; rounds towards the start.
    function automatic logic [TAP_W-1:0] eye_center(input logic [TAP_W-1:0] start,
                                                    input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] half;
        logic [LEN_W-1:0] sum;
        half = (len - LEN_W'(1)) >> 1;
        sum  = {1'b0, start} + half;
        return sum[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/adc366x_eye_trk.sv
// Per-lane passing-run tracker: remembers the current run and the widest
// (earliest on ties) run seen since the last clear.
module adc366x_eye_trk
    import adc366x_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             score_i,
    input  logic             pass_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [LEN_W-1:0] best_len_o
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [LEN_W-1:0] best_len_q, best_len_d;
    logic [TAP_W-1:0] new_start;
    logic [LEN_W-1:0] new_len;

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves it unassigned (no latch).
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        new_start    = (cur_len_q == '0) ? tap_i : cur_start_q;
        new_len      = cur_len_q + LEN_W'(1);
        if (clr_i) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (score_i) begin
            if (pass_i) begin
                cur_start_d = new_start;
                cur_len_d   = new_len;
                // Strictly greater keeps the earliest of equal-length runs.
                if (new_len > best_len_q) begin
                    best_len_d   = new_len;
                    best_start_d = new_start;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/adc366x_dly_cal.sv
// IDELAY calibration sequencer: sweeps all taps, scores each lane's eye and
// loads the eye centre; also forwards manual tap writes to the receiver.
module adc366x_dly_cal
    import adc366x_pkg::*;
#(
    parameter  int LW      = 2,
    parameter  int SETTLE  = 64,
    parameter  int WIN     = 256,
    parameter  int MIN_EYE = 4,
    parameter  int LD_W    = 4,
    localparam int SW      = 2*LW+1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cal_start_i,
    input  logic              cal_abort_i,
    input  logic [SW-1:0]     lane_ok_i,
    input  logic [5*SW-1:0]   man_dly_i,
    input  logic              man_load_i,
    output logic [5*SW:0]     cfg_dly_o,
    output logic              cal_busy_o,
    output logic              cal_done_o,
    output logic [SW-1:0]     cal_err_o,
    output logic [6*SW-1:0]   eye_len_o
);

    localparam int CNT_MAX = (WIN > SETTLE) ? ((WIN > LD_W) ? WIN : LD_W)
                                            : ((SETTLE > LD_W) ? SETTLE : LD_W);
    localparam int CNT_W   = $clog2(CNT_MAX+1);

    cal_st_t               state_q, state_d;
    logic [TAP_W-1:0]      t_q, t_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TAP_W*SW-1:0]   app_q, app_d;
    logic [TAP_W*SW-1:0]   sav_q, sav_d;
    logic [SW-1:0]         pass_q, pass_d;
    logic                  abrt_q, abrt_d;
    logic [TAP_W*SW:0]     cfg_q, cfg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [SW-1:0]         err_q, err_d;
    logic [LEN_W*SW-1:0]   eye_q, eye_d;
    logic                  trk_clr, trk_score, sweep_d;
    logic [TAP_W-1:0]      best_start [SW];
    logic [LEN_W-1:0]      best_len [SW];

    for (genvar i = 0; i < SW; i++) begin : g_trk
        adc366x_eye_trk u_trk (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .clr_i       (trk_clr),
            .score_i     (trk_score),
            .pass_i      (pass_q[i]),
            .tap_i       (t_q),
            .best_start_o(best_start[i]),
            .best_len_o  (best_len[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        app_d     = app_q;
        sav_d     = sav_q;
        pass_d    = pass_q;
        abrt_d    = abrt_q;
        err_d     = err_q;
        eye_d     = eye_q;
        trk_clr   = 1'b0;
        trk_score = 1'b0;

        case (state_q)
            ST_IDLE: if (!cal_abort_i) begin
                if (cal_start_i) begin
                    sav_d   = app_q;
                    t_d     = '0;
                    abrt_d  = 1'b0;
                    trk_clr = 1'b1;
                    state_d = ST_SET;
                end else if (man_load_i) begin
                    app_d   = man_dly_i;
                    cnt_d   = '0;
                    state_d = ST_LOAD_M;
                end
            end
            ST_SET: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LD_W-1)) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE-1)) begin
                    cnt_d   = '0;
                    pass_d  = '1;
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                pass_d = pass_q & lane_ok_i;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIN-1)) state_d = ST_SCORE;
            end
            ST_SCORE: begin
                trk_score = 1'b1;
                if (t_q == TAP_W'(NTAP-1)) begin
                    state_d = ST_CALC;
                end else begin
                    t_d     = t_q + TAP_W'(1);
                    state_d = ST_SET;
                end
            end
            ST_CALC: begin
                for (int i = 0; i < SW; i++) begin
                    if (best_len[i] >= LEN_W'(MIN_EYE)) begin
                        app_d[TAP_W*i +: TAP_W] = eye_center(best_start[i], best_len[i]);
                        err_d[i] = 1'b0;
                    end else begin
                        app_d[TAP_W*i +: TAP_W] = sav_q[TAP_W*i +: TAP_W];
                        err_d[i] = 1'b1;
                    end
                    eye_d[LEN_W*i +: LEN_W] = best_len[i];
                end
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                cnt_d   = '0;
                state_d = ST_APPLY_LD;
            end
            ST_APPLY_LD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LD_W-1)) state_d = abrt_q ? ST_IDLE : ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_LOAD_M: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LD_W-1)) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase

        // Abort overrides everything the sweep or CALC would have committed.
        if (cal_abort_i && (state_q inside {ST_SET, ST_LOAD, ST_SETTLE, ST_SAMPLE,
                                            ST_SCORE, ST_CALC})) begin
            app_d     = sav_q;
            err_d     = err_q;
            eye_d     = eye_q;
            trk_score = 1'b0;
            abrt_d    = 1'b1;
            state_d   = ST_APPLY;
        end

        // Outputs are registered from the next state so they align with it.
        sweep_d = state_d inside {ST_SET, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_SCORE};
        cfg_d   = '0;
        for (int i = 0; i < SW; i++) begin
            cfg_d[TAP_W*i +: TAP_W] = sweep_d ? t_d : app_d[TAP_W*i +: TAP_W];
        end
        cfg_d[TAP_W*SW] = state_d inside {ST_LOAD, ST_APPLY_LD, ST_LOAD_M};
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            app_q   <= '0;
            sav_q   <= '0;
            pass_q  <= '0;
            abrt_q  <= 1'b0;
            cfg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            eye_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            app_q   <= app_d;
            sav_q   <= sav_d;
            pass_q  <= pass_d;
            abrt_q  <= abrt_d;
            cfg_q   <= cfg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            eye_q   <= eye_d;
        end
    end

    assign cfg_dly_o  = cfg_q;
    assign cal_busy_o = busy_q;
    assign cal_done_o = done_q;
    assign cal_err_o  = err_q;
    assign eye_len_o  = eye_q;

endmodule

// File: tb/tb_adc366x_dly_cal.sv
// Self-checking bench for adc366x_dly_cal: table-driven eyes, random eyes
// against a brute-force eye model, plus abort, manual-load and reset sequences.
module tb_adc366x_dly_cal;

    localparam int SW   = 5;
    localparam int TCAL = 32*12 + 7;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cal_start, cal_abort, man_load;
    logic [SW-1:0] lane_ok;
    logic [24:0]   man_dly;
    logic [25:0]   cfg_dly;
    logic          busy, done;
    logic [4:0]    err;
    logic [29:0]   eye;
    logic [159:0]  masks = '1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [159:0] masks;
        logic [4:0]   pre;
        logic [24:0]  exp_taps;
        logic [4:0]   exp_err;
        logic [29:0]  exp_eye;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    adc366x_dly_cal #(.LW(2), .SETTLE(2), .WIN(4), .MIN_EYE(4), .LD_W(4)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .cal_start_i(cal_start),
        .cal_abort_i(cal_abort),
        .lane_ok_i  (lane_ok),
        .man_dly_i  (man_dly),
        .man_load_i (man_load),
        .cfg_dly_o  (cfg_dly),
        .cal_busy_o (busy),
        .cal_done_o (done),
        .cal_err_o  (err),
        .eye_len_o  (eye)
    );

    // Receiver model: a lane matches the pattern iff its applied tap lies in its mask.
    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < SW; i++) lane_ok[i] = masks[32*i + int'(cfg_dly[5*i +: 5])];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Widest passing run, earliest on ties, found by trying every (length, start).
    function automatic void model(input logic [31:0] m, input logic [4:0] sav,
                                  output logic [4:0] tap, output logic e,
                                  output logic [5:0] len);
        int bl = 0;
        int bs = 0;
        logic [63:0] w;
        for (int l = 32; l >= 1 && bl == 0; l--) begin
            w = (64'h1 << l) - 64'h1;
            for (int s = 0; s + l <= 32 && bl == 0; s++) begin
                if ((({32'h0, m} >> s) & w) == w) begin
                    bl = l;
                    bs = s;
                end
            end
        end
        len = 6'(bl);
        e   = (bl < 4);
        tap = e ? sav : 5'(bs + (bl - 1) / 2);
    endfunction

    task automatic preload(input logic [4:0] v);
        man_dly  = {SW{v}};
        man_load = 1'b1;
        @(negedge clk);
        man_load = 1'b0;
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        check("preload_idle", 64'(busy), 64'd0);
    endtask

    task automatic start_run(input bit same_man, input bit busy_man, output int cyc);
        cal_start = 1'b1;
        if (same_man) begin
            man_dly  = {SW{5'd7}};
            man_load = 1'b1;
        end
        @(negedge clk);
        cal_start = 1'b0;
        man_load  = 1'b0;
        cyc = 1;
        check("busy_rise", 64'(busy), 64'd1);
        check("set_tap0", 64'(cfg_dly), 64'd0);
        while (!done && cyc < 2000) begin
            if (busy_man && cyc == 50) begin
                man_dly  = {SW{5'd31}};
                man_load = 1'b1;
            end
            @(negedge clk);
            man_load = 1'b0;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int cyc, input logic [24:0] et,
                                input logic [4:0] ee, input logic [29:0] el);
        check({tag, "_done_cycle"}, 64'(cyc), 64'(TCAL));
        check({tag, "_taps"}, 64'(cfg_dly[24:0]), 64'(et));
        check({tag, "_strobe"}, 64'(cfg_dly[25]), 64'd0);
        check({tag, "_err"}, 64'(err), 64'(ee));
        check({tag, "_eye"}, 64'(eye), 64'(el));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          cyc;
        int          nstb;
        bit          saw_done;
        logic [4:0]  pre, tap1;
        logic        e1;
        logic [5:0]  l1;
        logic [24:0] et;
        logic [4:0]  ee;
        logic [29:0] el;
        logic [63:0] w;
        logic [31:0] m;
        int          s, l;

        tbl[0] = '{masks: {{4{32'hFFFF_FFFF}}, 32'h000F_FC00}, pre: 5'd0,
                   exp_taps: {5'd15, 5'd15, 5'd15, 5'd15, 5'd14}, exp_err: 5'b00000,
                   exp_eye: {6'd32, 6'd32, 6'd32, 6'd32, 6'd10}};
        tbl[1] = '{masks: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0FF0_0038, 32'h0000_1E3C, 32'hFFFF_FFFF},
                   pre: 5'd0, exp_taps: {5'd15, 5'd15, 5'd23, 5'd3, 5'd15}, exp_err: 5'b00000,
                   exp_eye: {6'd32, 6'd32, 6'd8, 6'd4, 6'd32}};
        tbl[2] = '{masks: {32'h0000_0380, {4{32'hFFFF_FFFF}}}, pre: 5'd6,
                   exp_taps: {5'd6, 5'd15, 5'd15, 5'd15, 5'd15}, exp_err: 5'b10000,
                   exp_eye: {6'd3, 6'd32, 6'd32, 6'd32, 6'd32}};
        tbl[3] = '{masks: {32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000F, 32'hF000_0000, 32'h8000_0000},
                   pre: 5'd9, exp_taps: {5'd15, 5'd9, 5'd1, 5'd29, 5'd9}, exp_err: 5'b01001,
                   exp_eye: {6'd32, 6'd0, 6'd4, 6'd4, 6'd1}};

        rstn = 1'b0; cal_start = 1'b0; cal_abort = 1'b0; man_load = 1'b0; man_dly = '0;
        repeat (3) @(negedge clk);
        check("rst_cfg", 64'(cfg_dly), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_err_eye", 64'({err, eye}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Manual load in IDLE: taps follow man_dly with a 4-cycle strobe.
        man_dly  = {SW{5'd17}};
        man_load = 1'b1;
        @(negedge clk);
        man_load = 1'b0;
        nstb = 0;
        for (int k = 0; k < 10; k++) begin
            if (cfg_dly[25]) begin
                nstb++;
                check("man_taps", 64'(cfg_dly[24:0]), 64'({SW{5'd17}}));
            end
            @(negedge clk);
        end
        check("man_strobe_len", 64'(nstb), 64'd4);
        check("man_final", 64'(cfg_dly), 64'({1'b0, {SW{5'd17}}}));
        check("man_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 4; v++) begin
            masks = tbl[v].masks;
            preload(tbl[v].pre);
            start_run(1'b0, v == 2, cyc);
            check_result($sformatf("vec%0d", v), cyc, tbl[v].exp_taps, tbl[v].exp_err,
                         tbl[v].exp_eye);
        end

        // Abort mid-SAMPLE at tap 9: restore saved taps, no done, results untouched.
        preload(5'd12);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (116) @(negedge clk);
        check("abort_at_tap9", 64'(cfg_dly), 64'({1'b0, {SW{5'd9}}}));
        cal_abort = 1'b1;
        @(negedge clk);
        cal_abort = 1'b0;
        check("abort_apply", 64'(cfg_dly), 64'({1'b0, {SW{5'd12}}}));
        nstb = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (cfg_dly[25]) begin
                nstb++;
                check("abort_taps", 64'(cfg_dly[24:0]), 64'({SW{5'd12}}));
            end
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_strobe_len", 64'(nstb), 64'd4);
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_err", 64'(err), 64'(tbl[3].exp_err));
        check("abort_eye", 64'(eye), 64'(tbl[3].exp_eye));

        // Start and manual load together: calibration wins.
        masks = '1;
        start_run(1'b1, 1'b0, cyc);
        check_result("start_man", cyc, {SW{5'd15}}, 5'b0, {SW{6'd32}});

        // Random eyes against the model.
        for (int r = 0; r < 6; r++) begin
            pre = 5'($urandom_range(0, 31));
            et = '0; ee = '0; el = '0;
            for (int i = 0; i < SW; i++) begin
                s = int'($urandom_range(0, 31));
                l = int'($urandom_range(0, 32 - s));
                w = ((64'h1 << l) - 64'h1) << s;
                m = w[31:0] | ($urandom & $urandom & $urandom);
                if ($urandom_range(0, 4) == 0) m = '0;
                masks[32*i +: 32] = m;
                model(m, pre, tap1, e1, l1);
                et[5*i +: 5] = tap1;
                ee[i]        = e1;
                el[6*i +: 6] = l1;
            end
            preload(pre);
            start_run(1'b0, 1'b0, cyc);
            check_result($sformatf("rand%0d", r), cyc, et, ee, el);
        end

        // Asynchronous reset mid-sweep, then a clean calibration.
        masks = '1;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (60) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_cfg", 64'(cfg_dly), 64'd0);
        check("arst_flags", 64'({busy, done, err, eye}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_idle", 64'(busy), 64'd0);
        masks = tbl[0].masks;
        start_run(1'b0, 1'b0, cyc);
        check_result("post_rst", cyc, tbl[0].exp_taps, tbl[0].exp_err, tbl[0].exp_eye);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
